// File: rtl/xy_mux_pipe.sv
// X/Y operand-select stage for the post-multiplier datapath, with optional opmode and output registers.
// Optional macro XY_MUX_ILLEGAL_CHECK_EN: force both muxes to 0 on an illegal opmode and keep a sticky flag.
module xy_mux_pipe #(
  parameter int W         = 48,
  parameter int MW        = 43,
  parameter int OPMODEREG = 1,
  parameter int OUTREG    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_opmode,
  input  logic                 ce_out,
  input  logic [3:0]           opmode,
  input  logic                 in_valid,
  input  logic signed [MW-1:0] m_in,
  input  logic [W-1:0]         p_in,
  input  logic [W-1:0]         ab_in,
  input  logic [W-1:0]         c_in,
  output logic [W-1:0]         x_out,
  output logic [W-1:0]         y_out,
  output logic                 out_valid,
  output logic                 illegal_sticky
);

  function automatic logic signed [W-1:0] sext_m(input logic signed [MW-1:0] m);
    return W'(m);
  endfunction

  logic [3:0]          opm_q;
  logic signed [W-1:0] x_sel;
  logic signed [W-1:0] y_sel;
  logic signed [W-1:0] x_mux;
  logic signed [W-1:0] y_mux;

  // Stage p0: opmode register
  generate
    if (OPMODEREG != 0) begin : g_opm_reg
      logic [3:0] opm_p0;
      always_ff @(posedge clk) begin
        if (rst)
          opm_p0 <= '0;
        else if (ce_opmode)
          opm_p0 <= opmode;
      end
      assign opm_q = opm_p0;
    end else begin : g_opm_comb
      assign opm_q = opmode;
    end
  endgenerate

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    case (opm_q[1:0])
      2'b00:   x_sel = '0;
      2'b01:   x_sel = sext_m(m_in);
      2'b10:   x_sel = p_in;
      default: x_sel = ab_in;
    endcase
    case (opm_q[3:2])
      2'b00:   y_sel = '0;
      2'b01:   y_sel = sext_m(m_in);
      2'b10:   y_sel = '1;
      default: y_sel = c_in;
    endcase
  end

`ifdef XY_MUX_ILLEGAL_CHECK_EN
  // The M partial product spans both X and Y, so selecting it on only one side is illegal.
  logic illegal;
  assign illegal = (opm_q[1:0] == 2'b01) ^ (opm_q[3:2] == 2'b01);
  assign x_mux   = illegal ? '0 : x_sel;
  assign y_mux   = illegal ? '0 : y_sel;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_sticky <= 1'b0;
    else if (illegal && in_valid)
      illegal_sticky <= 1'b1;
  end
`else
  assign x_mux          = x_sel;
  assign y_mux          = y_sel;
  assign illegal_sticky = 1'b0;
`endif

  // Stage p1: output register
  generate
    if (OUTREG != 0) begin : g_out_reg
      logic signed [W-1:0] x_p1;
      logic signed [W-1:0] y_p1;
      logic                vld_p1;
      always_ff @(posedge clk) begin
        if (rst) begin
          x_p1   <= '0;
          y_p1   <= '0;
          vld_p1 <= 1'b0;
        end else if (ce_out) begin
          x_p1   <= x_mux;
          y_p1   <= y_mux;
          vld_p1 <= in_valid;
        end
      end
      assign x_out     = x_p1;
      assign y_out     = y_p1;
      assign out_valid = vld_p1;
    end else begin : g_out_comb
      assign x_out     = x_mux;
      assign y_out     = y_mux;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_xy_mux_pipe.sv
// Directed bench for xy_mux_pipe: registered default instance plus a fully combinational instance.
module tb_xy_mux_pipe;

`ifdef XY_MUX_ILLEGAL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_opmode;
  logic        ce_out;
  logic [3:0]  opmode;
  logic        in_valid;
  logic [42:0] m_in;
  logic [47:0] p_in;
  logic [47:0] ab_in;
  logic [47:0] c_in;
  logic [47:0] x_out, y_out, x2, y2;
  logic        out_valid, illegal_sticky, v2, s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xy_mux_pipe #(.W(48), .MW(43), .OPMODEREG(1), .OUTREG(1)) dut (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_out(ce_out), .opmode(opmode),
    .in_valid(in_valid), .m_in(m_in), .p_in(p_in), .ab_in(ab_in), .c_in(c_in),
    .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .illegal_sticky(illegal_sticky)
  );

  xy_mux_pipe #(.W(48), .MW(43), .OPMODEREG(0), .OUTREG(0)) dut_comb (
    .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_out(ce_out), .opmode(opmode),
    .in_valid(in_valid), .m_in(m_in), .p_in(p_in), .ab_in(ab_in), .c_in(c_in),
    .x_out(x2), .y_out(y2), .out_valid(v2), .illegal_sticky(s2)
  );

  typedef struct {
    logic [3:0]  opm;
    logic        vld;
    logic [42:0] m;
    logic [47:0] p;
    logic [47:0] ab;
    logic [47:0] c;
    logic [47:0] ex;
    logic [47:0] ey;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opmode   = v.opm;
    in_valid = v.vld;
    m_in     = v.m;
    p_in     = v.p;
    ab_in    = v.ab;
    c_in     = v.c;
  endtask

  initial begin
    vecs[0] = '{4'b1000, 1'b1, 43'h123_4567_89AB, 48'h1111_2222_3333, 48'h4444_5555_6666, 48'h7777_8888_9999,
                48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF};
    vecs[1] = '{4'b1111, 1'b1, 43'h000_0000_0042, 48'h0000_0000_0099, 48'h0BAD_0000_CAFE, 48'h0000_1234_5678,
                48'h0BAD_0000_CAFE, 48'h0000_1234_5678};
    vecs[2] = '{4'b0101, 1'b1, 43'h400_0000_0001, 48'h0000_0000_1111, 48'h0000_0000_2222, 48'h0000_0000_3333,
                48'hFC00_0000_0001, 48'hFC00_0000_0001};
    vecs[3] = '{4'b0101, 1'b1, 43'h000_0000_0007, 48'h0000_0000_1111, 48'h0000_0000_2222, 48'h0000_0000_3333,
                48'h0000_0000_0007, 48'h0000_0000_0007};
    vecs[4] = '{4'b0010, 1'b1, 43'h7FF_FFFF_FFFF, 48'h0000_0000_ABCD, 48'hDEAD_BEEF_0000, 48'h5555_5555_5555,
                48'h0000_0000_ABCD, 48'h0000_0000_0000};
    vecs[5] = '{4'b1110, 1'b0, 43'h000_0000_0001, 48'h8000_0000_0001, 48'h0000_0000_0002, 48'hA5A5_A5A5_A5A5,
                48'h8000_0000_0001, 48'hA5A5_A5A5_A5A5};
    vecs[6] = '{4'b0011, 1'b1, 43'h000_0000_0003, 48'h0000_0000_0004, 48'hFEDC_BA98_7654, 48'h0000_0000_0005,
                48'hFEDC_BA98_7654, 48'h0000_0000_0000};
    vecs[7] = '{4'b0000, 1'b1, 43'h3FF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
                48'h0000_0000_0000, 48'h0000_0000_0000};
    vecs[8] = '{4'b1011, 1'b1, 43'h000_0000_0000, 48'h0000_0000_0000, 48'h0123_4567_89AB, 48'h0000_0000_0000,
                48'h0123_4567_89AB, 48'hFFFF_FFFF_FFFF};

    // Reset with random inputs and all enables high
    rst = 1'b1; ce_opmode = 1'b1; ce_out = 1'b1;
    opmode = 4'($urandom); in_valid = 1'b1;
    m_in = 43'({$urandom, $urandom}); p_in = 48'({$urandom, $urandom});
    ab_in = 48'({$urandom, $urandom}); c_in = 48'({$urandom, $urandom});
    step(1);
    chk("rst_x", x_out, 48'h0);
    chk("rst_y", y_out, 48'h0);
    chk("rst_vld", {47'h0, out_valid}, 48'h0);
    chk("rst_sticky", {47'h0, illegal_sticky}, 48'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("comb_x[%0d]", i), x2, vecs[i].ex);
      chk($sformatf("comb_y[%0d]", i), y2, vecs[i].ey);
      chk($sformatf("comb_vld[%0d]", i), {47'h0, v2}, {47'h0, vecs[i].vld});
      step(2);
      chk($sformatf("x[%0d]", i), x_out, vecs[i].ex);
      chk($sformatf("y[%0d]", i), y_out, vecs[i].ey);
      chk($sformatf("vld[%0d]", i), {47'h0, out_valid}, {47'h0, vecs[i].vld});
      chk($sformatf("sticky[%0d]", i), {47'h0, illegal_sticky}, 48'h0);
    end

    // Latency: a new opmode reaches x_out after two edges, not one
    drive(vecs[6]);  // x = ab, steady
    step(2);
    opmode = 4'b0010; p_in = 48'h0000_0000_0F0F;
    step(1);
    chk("lat1_x", x_out, 48'hFEDC_BA98_7654);
    step(1);
    chk("lat2_x", x_out, 48'h0000_0000_0F0F);

    // ce_out low: outputs and valid hold while inputs change
    drive(vecs[1]);
    step(2);
    ce_out = 1'b0;
    opmode = 4'b0000; in_valid = 1'b0; c_in = 48'h0000_0000_0001; ab_in = 48'h0000_0000_0002;
    step(2);
    chk("hold_x", x_out, 48'h0BAD_0000_CAFE);
    chk("hold_y", y_out, 48'h0000_1234_5678);
    chk("hold_vld", {47'h0, out_valid}, 48'h1);

    // ce_opmode low: previous selection (1111) persists, new data flows through
    drive(vecs[1]);
    ce_out = 1'b1;
    step(2);
    ce_opmode = 1'b0;
    opmode = 4'b0000; c_in = 48'h0000_0000_00C0; ab_in = 48'h0000_0000_00AB;
    step(2);
    chk("opmhold_x", x_out, 48'h0000_0000_00AB);
    chk("opmhold_y", y_out, 48'h0000_0000_00C0);

    // Reset wins over disabled clock enables
    ce_out = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstce_x", x_out, 48'h0);
    chk("rstce_y", y_out, 48'h0);
    chk("rstce_vld", {47'h0, out_valid}, 48'h0);
    ce_out = 1'b1; ce_opmode = 1'b1;

    // Illegal opmode: X selects M but Y does not
    opmode = 4'b0001; in_valid = 1'b1; m_in = 43'h400_0000_0005;
    step(2);
    chk("ill_x", x_out, CHK_EN ? 48'h0 : 48'hFC00_0000_0005);
    chk("ill_y", y_out, 48'h0);
    chk("ill_sticky", {47'h0, illegal_sticky}, {47'h0, CHK_EN});
    chk("ill_comb_x", x2, CHK_EN ? 48'h0 : 48'hFC00_0000_0005);
    chk("ill_comb_sticky", {47'h0, s2}, {47'h0, CHK_EN});
    drive(vecs[1]);
    step(2);
    chk("ill_after_x", x_out, 48'h0BAD_0000_CAFE);
    chk("ill_after_sticky", {47'h0, illegal_sticky}, {47'h0, CHK_EN});
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("ill_rst_sticky", {47'h0, illegal_sticky}, 48'h0);
    chk("ill_rst_comb_sticky", {47'h0, s2}, 48'h0);

    // Illegal code without in_valid never sets the flag
    opmode = 4'b0100; in_valid = 1'b0;
    step(3);
    chk("ill_novld_sticky", {47'h0, illegal_sticky}, 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
